inv_addkey_mixcol_stage: RTL
============================

// Module: inv_addkey_mixcol_stage
// PURPOSE
//  Pipelined decryption-round back end. Consumes the 128-bit state produced by inv_subbytes,
//  XORs in the round key (AddRoundKey), then applies InvMixColumns unless this is the final round.
//  Two register stages with valid/ready flow control, so a round engine or unrolled pipeline can stall.
//  Sits between inv_subbytes and the next round's inv_shiftrows / ciphertext-out logic.
// PARAMETERS
//  NR        10   number of cipher rounds; in_round is valid in 0..NR (10/12/14 for AES-128/192/256)
//  RW         4   width of round index ports; must satisfy 2**RW > NR
// PORTS
//  clk        in   1    clock, all state on rising edge
//  reset      in   1    asynchronous, active-high reset
//  in_valid   in   1    upstream state/key/round valid
//  in_ready   out  1    stage can accept this cycle
//  in_state   in   128  state from inv_subbytes; byte k at [127-8k -: 8], column c = bytes 4c..4c+3
//  in_key     in   128  round key, same byte order
//  in_round   in   RW   round index; 0 = final round (no InvMixColumns)
//  out_valid  out  1    out_state valid
//  out_ready  in   1    downstream accepts
//  out_state  out  128  round result
//  out_round  out  RW   in_round carried with the data
//  out_last   out  1    1 when the carried round index was 0
//  round_err  out  1    sticky: set when a beat with in_round > NR is accepted
// BEHAVIOUR
//  - Reset (async assert, sync release): v1=v2=0; stage registers, out_state, out_round, out_last, round_err = 0.
//  - Stage 1 (S1): on accept (in_valid & in_ready), captures in_state ^ in_key, in_round, last=(in_round==0).
//  - Stage 2 (S2): on advance, captures S1 data after InvMixColumns, or S1 data unchanged if last=1;
//    also copies round/last. out_* come straight from S2 registers.
//  - InvMixColumns per column [a0..a3]: b_i = 0e*a_i ^ 0b*a_(i+1) ^ 0d*a_(i+2) ^ 09*a_(i+3), indices mod 4.
//    GF(2^8) with xtime reduction poly 0x11B; built from xtime chains, no lookup tables.
//  - Flow control, all combinational, no bubbles:
//    adv2 = !v2 | out_ready;  adv1 = v1 & adv2;  in_ready = !v1 | adv2.
//    v2 <= v1 when adv2;  v1 <= in_valid when in_ready.
//    S1/S2 data registers load only on accept/advance; they hold while stalled.
//  - Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1 when not stalled.
//    Throughput is 1 beat/clk when out_ready=1.
//  - Stall: out_valid=1 and out_ready=0 -> out_state/out_round/out_last stable.
//    S1 may still fill once, then in_ready=0.
//  - Simultaneous accept into a full S1 while S2 drains is legal; S1 is overwritten only with adv2=1.
//  - Ordering: beats leave in acceptance order; none dropped or duplicated.
//  - in_round > NR: beat still processed as a non-final round; round_err set until reset.
//  - Reset mid-operation: in-flight beats are discarded; out_valid=0 in the cycle reset asserts.
//  - out_valid never depends combinationally on in_valid.
//  - in_ready depends combinationally on out_ready (documented path).
// TESTING
//  1 Mix: state={8e4da1bc,9fdc589d,01010101,c6c6c6c6}, key=0, round=5, out_ready=1
//    -> out_state={db135345,f20a225c,01010101,c6c6c6c6}, out_round=5, out_last=0.
//  2 Final round: state=00112233_44556677_8899aabb_ccddeeff, key=000102..0f, round=0
//    -> out_state=00102030_40506070_8090a0b0_c0d0e0f0, out_last=1.
//  3 Throughput: 4 back-to-back beats (rounds 3,2,1,0), out_ready=1 -> out_valid high 4 consecutive
//    cycles starting 1 cycle after first accept, in order.
//  4 Backpressure: hold out_ready=0 with 3 beats offered -> 2 accepted, in_ready=0, out_state stable;
//    release -> both beats delivered in order, third then accepted.
//  5 Reset mid-flight: assert reset with v1=v2=1 -> out_valid=0 immediately.
//    After release, the first new beat emerges clean with no stale data.
//  6 Bad round: accept in_round=NR+1 -> round_err=1 and stays 1; data still InvMixColumns-processed.

Source files
------------

// File: rtl/inv_addkey_mixcol_stage.sv
// inv_addkey_mixcol_stage
//   Back end of an AES decryption round. Takes the state coming out of
//   inv_subbytes, XORs in the round key, then applies InvMixColumns unless
//   the beat belongs to the final round (round index 0). Two register stages
//   with valid/ready handshaking so the surrounding round engine can stall.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream beat valid
//   in_ready   this stage can accept a beat this cycle
//   in_state   128-bit state, byte k at [127-8k -: 8], column c = bytes 4c..4c+3
//   in_key     128-bit round key, same byte order
//   in_round   round index, 0 = final round (InvMixColumns skipped)
//   out_valid  out_state/out_round/out_last valid
//   out_ready  downstream accepts
//   out_state  round result
//   out_round  round index carried with the data
//   out_last   carried round index was 0
//   round_err  sticky flag: a beat with in_round > NR was accepted
//
// in_ready depends combinationally on out_ready; out_valid is purely registered.

module inv_addkey_mixcol_stage #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_state,
  input  logic [127:0]  in_key,
  input  logic [RW-1:0] in_round,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_state,
  output logic [RW-1:0] out_round,
  output logic          out_last,
  output logic          round_err
);

  // GF(2^8) doubling, reduction polynomial 0x11B
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    b1 = mul0e(a1) ^ mul0b(a2) ^ mul0d(a3) ^ mul09(a0);
    b2 = mul0e(a2) ^ mul0b(a3) ^ mul0d(a0) ^ mul09(a1);
    b3 = mul0e(a3) ^ mul0b(a0) ^ mul0d(a1) ^ mul09(a2);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] inv_mix_state(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  logic          vld_p1, vld_p2;
  logic [127:0]  state_p1, state_p2;
  logic [RW-1:0] round_p1, round_p2;
  logic          last_p1, last_p2;
  logic          adv2, accept;
  logic [127:0]  mixed_p1;

  assign adv2     = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv2;
  assign accept   = in_valid && in_ready;
  assign mixed_p1 = last_p1 ? state_p1 : inv_mix_state(state_p1);

  // ---- stage 1: AddRoundKey ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      state_p1  <= '0;
      round_p1  <= '0;
      last_p1   <= 1'b0;
      round_err <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (accept) begin
        state_p1 <= in_state ^ in_key;
        round_p1 <= in_round;
        last_p1  <= (in_round == '0);
        // out-of-range rounds still go through InvMixColumns; only flagged
        if (in_round > RW'(NR)) round_err <= 1'b1;
      end
    end
  end

  // ---- stage 2: InvMixColumns (bypassed on the final round) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2   <= 1'b0;
      state_p2 <= '0;
      round_p2 <= '0;
      last_p2  <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        state_p2 <= mixed_p1;
        round_p2 <= round_p1;
        last_p2  <= last_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_state = state_p2;
  assign out_round = round_p2;
  assign out_last  = last_p2;

endmodule
